// File: rtl/delay.sv
// Delayed, stretched pulse generator: a rising edge on din produces a dout
// pulse DELAY_CYC cycles later that lasts HOLD_CYC cycles, retriggerable
// while the pulse is high.
module delay #(
    parameter int unsigned DELAY_CYC = 3,
    parameter int unsigned HOLD_CYC  = 5,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             din_q,   din_d;
    logic             dout_q,  dout_d;
    logic             trig_c;

    // Edge detect, next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        din_d   = din;
        trig_c  = din & ~din_q;

        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                if (trig_c) begin
                    state_d = WAIT;
                    cnt_d   = DELAY_LOAD;
                end
            end
            WAIT: begin
                // Triggers are ignored here so the pending pulse keeps its timing
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    dout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                dout_d = 1'b1;
                if (trig_c) begin
                    // A retrigger, even on the final cycle, extends the pulse
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    dout_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    // State, counter, input history and output registers
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_delay.sv
// Directed bench for delay: default instance plus a DELAY_CYC=1/HOLD_CYC=1 instance.
module tb_delay;

    logic clk;
    logic n_rst;
    logic din_a, din_b;
    logic dout_a, dout_b;

    int unsigned n_checks;
    int unsigned n_fail;

    delay dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .din   (din_a),
        .dout  (dout_a)
    );

    delay #(
        .DELAY_CYC (1),
        .HOLD_CYC  (1),
        .CNT_W     (8)
    ) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .din   (din_b),
        .dout  (dout_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of din_pat is applied before edge i; bit i of exp_pat is dout after edge i
    task automatic run_seq(input string tag, input bit sel_b, input logic [31:0] din_pat,
                           input logic [31:0] exp_pat, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_b) din_b = din_pat[i];
            else       din_a = din_pat[i];
            tick();
            check($sformatf("%s[%0d]", tag, i), sel_b ? dout_b : dout_a, exp_pat[i]);
        end
        din_a = 1'b0;
        din_b = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        din_a    = 1'b0;
        din_b    = 1'b0;
        #1 n_rst = 1'b1;
        #1;
        check("rst_a_async", dout_a, 1'b0);
        check("rst_b_async", dout_b, 1'b0);
        tick();
        tick();
        check("rst_a_clk", dout_a, 1'b0);
        check("rst_b_clk", dout_b, 1'b0);
        n_rst = 1'b0;

        // Single 1-cycle pulse: high after edges 3..7
        run_seq("single", 1'b0, 32'h0000_0001, 32'h0000_00F8, 12);
        // din held 20 cycles: one pulse only
        run_seq("held", 1'b0, 32'h000F_FFFF, 32'h0000_00F8, 28);
        // Second trigger during WAIT is ignored
        run_seq("in_wait", 1'b0, 32'h0000_0005, 32'h0000_00F8, 12);
        // Retrigger on third HOLD cycle: high after edges 3..9
        run_seq("in_hold", 1'b0, 32'h0000_0021, 32'h0000_03F8, 14);
        // Back in IDLE: fresh trigger has the full latency again
        run_seq("again", 1'b0, 32'h0000_0001, 32'h0000_00F8, 10);

        // Reset mid-HOLD drops dout without a clock edge
        run_seq("pre_rst", 1'b0, 32'h0000_0001, 32'h0000_0018, 5);
        #2 n_rst = 1'b1;
        #1;
        check("rst_mid_hold", dout_a, 1'b0);
        tick();
        check("rst_hold_clk", dout_a, 1'b0);
        n_rst = 1'b0;
        run_seq("post_rst", 1'b0, 32'h0000_0000, 32'h0000_0000, 10);

        // din high at first edge after release is a trigger
        n_rst = 1'b1;
        din_a = 1'b1;
        tick();
        check("rst_din_hi", dout_a, 1'b0);
        n_rst = 1'b0;
        run_seq("rel_trig", 1'b0, 32'h0000_03FF, 32'h0000_00F8, 12);

        // DELAY_CYC=1, HOLD_CYC=1: high after edge 1 only
        run_seq("min", 1'b1, 32'h0000_0001, 32'h0000_0002, 5);
        // Retrigger on the cnt=0 HOLD edge extends by one cycle
        run_seq("min_ext", 1'b1, 32'h0000_0005, 32'h0000_0006, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/delay.md
DELAY -- requirements
Module: delay

Interface
REQ-001 The module SHALL be named delay and SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DELAY_CYC, default 3: clock cycles from a detected din rising edge to dout assertion; legal range 1..255.
REQ-003 Parameter HOLD_CYC, default 5: clock cycles dout stays high per trigger; legal range 1..255.
REQ-004 Parameter CNT_W, default 8: width of the internal down-counter; it SHALL hold max(DELAY_CYC, HOLD_CYC).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 n_rst  input  1  asynchronous reset, asserted HIGH (name kept per codebase port naming); clears all state immediately.
REQ-007 din  input  1  trigger input, synchronous to clk; only its rising edge is significant.
REQ-008 dout  output  1  delayed, stretched pulse; driven directly from a flip-flop, with no combinational path from din.

Function
REQ-009 din SHALL be registered every cycle into din_q; a trigger SHALL be detected in any cycle where din=1 and din_q=0, sampled at the same clk edge.
REQ-010 FSM states SHALL be IDLE, WAIT and HOLD, with a single down-counter cnt of width CNT_W.
REQ-011 IDLE: on a trigger, go to WAIT and load cnt=DELAY_CYC-1; dout=0.
REQ-012 WAIT: decrement cnt each cycle; when cnt=0, go to HOLD, load cnt=HOLD_CYC-1 and set dout=1 on that same edge.
REQ-013 Latency: for a trigger sampled at edge k, dout SHALL be 1 after edge k+DELAY_CYC.
REQ-014 HOLD: decrement cnt each cycle; when cnt=0 and no trigger is present, go to IDLE and clear dout.
REQ-015 dout SHALL be high for exactly HOLD_CYC consecutive cycles per untriggered hold period.
REQ-016 A trigger during WAIT SHALL be ignored; timing of the pending pulse is unchanged.
REQ-017 A trigger during HOLD, including at the cnt=0 edge, SHALL reload cnt=HOLD_CYC-1, stay in HOLD and keep dout=1, extending the pulse by HOLD_CYC cycles from that edge.
REQ-018 din held high continuously SHALL count as one trigger only; it must return low before a new edge is recognised.
REQ-019 din pulses of one cycle SHALL be sufficient to trigger.
REQ-020 cnt SHALL never wrap; it is only decremented while nonzero and only reloaded as specified above.

Reset
REQ-021 While n_rst=1, state SHALL be IDLE, cnt=0, din_q=0 and dout=0, asynchronously and regardless of clk.
REQ-022 Reset asserted mid-WAIT or mid-HOLD SHALL abort the operation with dout=0 immediately; no pulse resumes after release.
REQ-023 Because din_q resets to 0, din=1 at the first clk edge after release SHALL be treated as a trigger.
REQ-024 The first functional clk edge SHALL be the first rising edge with n_rst=0.

Verification
REQ-025 Defaults. Release reset, then a 1-cycle din pulse sampled at edge k -> dout=0 through edge k+2, dout=1 after edges k+3..k+7, dout=0 after edge k+8, and the FSM is back in IDLE.
REQ-026 Defaults. din held high 20 cycles -> exactly one 5-cycle dout pulse, starting 3 cycles after the rising edge.
REQ-027 Defaults. Second din pulse 1 cycle after the first (during WAIT) -> single 5-cycle pulse with unchanged timing.
REQ-028 Defaults. Second din pulse at the 3rd cycle of HOLD -> dout stays high continuously, ending 5 cycles after that trigger edge (7 high cycles total).
REQ-029 Defaults. n_rst raised during HOLD -> dout falls immediately without a clk edge; after release with din=0, dout stays 0.
REQ-030 DELAY_CYC=1, HOLD_CYC=1. 1-cycle trigger at edge k -> dout=1 after edge k+1 only, 0 after edge k+2.
